// File: rtl/conv_requant_packer.sv
// rtl/conv_requant_packer.sv - requantizes int32 accumulators to int8 and packs 16 lanes per output word
// Optional int8 saturation counter is built when REQUANT_SAT_CNT_EN is defined.
module conv_requant_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int BUS_WIDTH  = 128,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [15:0]           cfg_scale,
  input  logic [4:0]            cfg_shift,
  input  logic [1:0]            cfg_act_mode,
  input  logic [DATA_WIDTH-1:0] cfg_clip_max,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACC_WIDTH-1:0]  in_acc,
  input  logic [ACC_WIDTH-1:0]  in_bias,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [BUS_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic [15:0]           sat_count
);
  localparam int LANES  = BUS_WIDTH / DATA_WIDTH;
  localparam int IDX_W  = $clog2(LANES);
  localparam int PROD_W = ACC_WIDTH + 16;
  localparam logic signed [PROD_W-1:0] Q_MAX = PROD_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

  state_t state_q, state_d;

  logic [15:0]                  cfg_scale_q, cfg_scale_d;
  logic [4:0]                   cfg_shift_q, cfg_shift_d;
  logic [1:0]                   cfg_mode_q, cfg_mode_d;
  logic signed [DATA_WIDTH-1:0] cfg_clip_q, cfg_clip_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;

  logic                     s1_valid_q, s1_valid_d;
  logic [ACC_WIDTH-1:0]     s1_b_q, s1_b_d;
  logic                     s1_last_q, s1_last_d;
  logic                     s2_valid_q, s2_valid_d;
  logic signed [PROD_W-1:0] s2_p_q, s2_p_d;
  logic                     s2_last_q, s2_last_d;
  logic                     s3_valid_q, s3_valid_d;
  logic [DATA_WIDTH-1:0]    s3_byte_q, s3_byte_d;
  logic                     s3_last_q, s3_last_d;

  logic [BUS_WIDTH-1:0]  pack_q, pack_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [BUS_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;

  logic                         stall, accept, out_hs, start_ok, word_done;
  logic [ACC_WIDTH:0]           acc_sum;
  logic [ACC_WIDTH-1:0]         acc_sat;
  logic signed [PROD_W-1:0]     prod, rnd, rounded;
  logic signed [DATA_WIDTH-1:0] q_val, act_val;
  logic [BUS_WIDTH-1:0]         word_next;

  assign stall     = out_valid_q & ~out_ready;
  assign out_hs    = out_valid_q & out_ready;
  assign in_ready  = (state_q == ST_RUN) & ~stall;
  assign accept    = in_valid & in_ready;
  assign start_ok  = start & (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && in_last) state_d = ST_FLUSH;
      ST_FLUSH: if (out_hs && out_last_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Arithmetic: bias add with int32 clamp, scale, rounding shift, int8 clamp, activation.
  always_comb begin
    acc_sum = {in_acc[ACC_WIDTH-1], in_acc} + {in_bias[ACC_WIDTH-1], in_bias};
    acc_sat = acc_sum[ACC_WIDTH-1:0];
    if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1])
      acc_sat = {acc_sum[ACC_WIDTH], {(ACC_WIDTH-1){~acc_sum[ACC_WIDTH]}}};

    // Low PROD_W bits of the product are exact since |b * scale| < 2^47.
    prod = {{(PROD_W-ACC_WIDTH){s1_b_q[ACC_WIDTH-1]}}, s1_b_q} * {{ACC_WIDTH{1'b0}}, cfg_scale_q};

    rnd     = (cfg_shift_q == 5'd0) ? '0 : (PROD_W'(1) << (cfg_shift_q - 5'd1));
    rounded = (s2_p_q + rnd) >>> cfg_shift_q;

    if (rounded > Q_MAX)      q_val = Q_MAX[DATA_WIDTH-1:0];
    else if (rounded < Q_MIN) q_val = Q_MIN[DATA_WIDTH-1:0];
    else                      q_val = rounded[DATA_WIDTH-1:0];

    act_val = q_val;
    if (cfg_mode_q == 2'b01 || cfg_mode_q == 2'b10) begin
      if (q_val[DATA_WIDTH-1]) act_val = '0;
      if (cfg_mode_q == 2'b10 && act_val > cfg_clip_q) act_val = cfg_clip_q;
    end

    word_next = pack_q;
    word_next[idx_q*DATA_WIDTH +: DATA_WIDTH] = s3_byte_q;
    word_done = s3_valid_q & ((idx_q == IDX_W'(LANES - 1)) | s3_last_q);
  end

  always_comb begin
    cfg_scale_d = cfg_scale_q;
    cfg_shift_d = cfg_shift_q;
    cfg_mode_d  = cfg_mode_q;
    cfg_clip_d  = cfg_clip_q;
    addr_d      = addr_q;
    s1_valid_d  = s1_valid_q;
    s1_b_d      = s1_b_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_p_d      = s2_p_q;
    s2_last_d   = s2_last_q;
    s3_valid_d  = s3_valid_q;
    s3_byte_d   = s3_byte_q;
    s3_last_d   = s3_last_q;
    pack_d      = pack_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (start_ok) begin
      cfg_scale_d = cfg_scale;
      cfg_shift_d = cfg_shift;
      cfg_mode_d  = cfg_act_mode;
      cfg_clip_d  = cfg_clip_max;
      addr_d      = cfg_base_addr;
      pack_d      = '0;
      idx_d       = '0;
    end

    if (!stall) begin
      s1_valid_d = accept;
      s1_b_d     = acc_sat;
      s1_last_d  = in_last;
      s2_valid_d = s1_valid_q;
      s2_p_d     = prod;
      s2_last_d  = s1_last_q;
      s3_valid_d = s2_valid_q;
      s3_byte_d  = act_val;
      s3_last_d  = s2_last_q;
    end

    if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    // A completed word may load on the same edge the previous word leaves.
    if (!stall && s3_valid_q) begin
      if (word_done) begin
        out_valid_d = 1'b1;
        out_data_d  = word_next;
        out_addr_d  = addr_q;
        out_last_d  = s3_last_q;
        addr_d      = addr_q + ADDR_WIDTH'(1);
        pack_d      = '0;
        idx_d       = '0;
      end else begin
        pack_d = word_next;
        idx_d  = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_scale_q <= '0;
      cfg_shift_q <= '0;
      cfg_mode_q  <= '0;
      cfg_clip_q  <= '0;
      addr_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_b_q      <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_p_q      <= '0;
      s2_last_q   <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_byte_q   <= '0;
      s3_last_q   <= 1'b0;
      pack_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cfg_scale_q <= cfg_scale_d;
      cfg_shift_q <= cfg_shift_d;
      cfg_mode_q  <= cfg_mode_d;
      cfg_clip_q  <= cfg_clip_d;
      addr_q      <= addr_d;
      s1_valid_q  <= s1_valid_d;
      s1_b_q      <= s1_b_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_p_q      <= s2_p_d;
      s2_last_q   <= s2_last_d;
      s3_valid_q  <= s3_valid_d;
      s3_byte_q   <= s3_byte_d;
      s3_last_q   <= s3_last_d;
      pack_q      <= pack_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef REQUANT_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic        sat_hit;

  // Only the int8 clamp counts; activation clamps are deliberate.
  assign sat_hit = s2_valid_q & ~stall & ((rounded > Q_MAX) | (rounded < Q_MIN));

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (start_ok)                              sat_cnt_d = '0;
    else if (sat_hit && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_conv_requant_packer.sv
// tb/tb_conv_requant_packer.sv - directed vectors and multi-cycle sequences for conv_requant_packer
module tb_conv_requant_packer;
  logic         clk = 1'b0;
  logic         rst, start, in_valid, in_last, out_ready;
  logic [17:0]  cfg_base_addr;
  logic [15:0]  cfg_scale;
  logic [4:0]   cfg_shift;
  logic [1:0]   cfg_act_mode;
  logic [7:0]   cfg_clip_max;
  logic [31:0]  in_acc, in_bias;
  logic         busy, done, in_ready, out_valid, out_last;
  logic [17:0]  out_addr;
  logic [127:0] out_data;
  logic [15:0]  sat_count;

  always #5 clk = ~clk;

  conv_requant_packer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_act_mode(cfg_act_mode),
    .cfg_clip_max(cfg_clip_max), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_bias(in_bias),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .sat_count(sat_count)
  );

  typedef struct {
    logic [15:0] scale;
    logic [4:0]  shift;
    logic [1:0]  mode;
    logic [7:0]  clip;
    logic [31:0] acc;
    logic [31:0] bias;
    logic [7:0]  exp_byte;
    int          exp_sat;
  } vec_t;

  typedef struct {
    logic [17:0]  addr;
    logic [127:0] data;
    logic         last;
  } word_t;

  int    checks = 0;
  int    failures = 0;
  int    sat_en;
  int    cyc = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
  word_t words[$];
  vec_t  vecs[16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (out_valid && out_ready) begin
      words.push_back('{out_addr, out_data, out_last});
      if (out_last) last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_job(input logic [17:0] base, input logic [15:0] scale, input logic [4:0] shift,
                           input logic [1:0] mode, input logic [7:0] clip);
    cfg_base_addr = base;
    cfg_scale = scale;
    cfg_shift = shift;
    cfg_act_mode = mode;
    cfg_clip_max = clip;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    words.delete();
    done_cnt = 0;
  endtask

  task automatic send_beat(input logic [31:0] acc, input logic [31:0] bias, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_acc = acc;
    in_bias = bias;
    in_last = last;
    #1;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("beat_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    #1;
    while (busy && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({tag, "_idle"}, busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [17:0] addr,
                            input logic [127:0] data, input logic last);
    if (words.size() > idx) begin
      check({tag, "_addr"}, words[idx].addr, addr);
      check({tag, "_data"}, words[idx].data, data);
      check({tag, "_last"}, words[idx].last, last);
    end else begin
      check({tag, "_present"}, 128'(words.size()), 128'(idx + 1));
    end
  endtask

  task automatic run_vector(input int n, input vec_t v);
    int          lat;
    logic [17:0] base;
    string       tag;
    tag = $sformatf("vec%0d", n);
    base = 18'h00100 + 18'(n);
    start_job(base, v.scale, v.shift, v.mode, v.clip);
    send_beat(v.acc, v.bias, 1'b1);
    lat = 0;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_data"}, out_data, {120'd0, v.exp_byte});
    check({tag, "_addr"}, out_addr, base);
    check({tag, "_last"}, out_last, 1'b1);
    check({tag, "_sat_count"}, sat_count, (sat_en != 0) ? v.exp_sat : 0);
    wait_idle(tag);
    check({tag, "_words"}, words.size(), 1);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic run_count16(input string tag);
    start_job(18'h00040, 16'd1, 5'd0, 2'b00, 8'd0);
    for (int i = 0; i < 16; i++) send_beat(32'(i), 32'd0, i == 15);
    wait_idle(tag);
    check({tag, "_words"}, words.size(), 1);
    check_word(tag, 0, 18'h00040, 128'h0F0E0D0C0B0A09080706050403020100, 1'b1);
    check({tag, "_done_delay"}, done_cyc, last_hs_cyc + 1);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [127:0] exp0, exp1;
`ifdef REQUANT_SAT_CNT_EN
    sat_en = 1;
`else
    sat_en = 0;
`endif
    vecs[0]  = '{16'd1,     5'd3,  2'b00, 8'd0,  32'd1000,     32'd24,       8'h7F, 1};
    vecs[1]  = '{16'd3,     5'd2,  2'b01, 8'd0,  32'hFFFFFED4, 32'd0,        8'h00, 1};
    vecs[2]  = '{16'd3,     5'd2,  2'b00, 8'd0,  32'hFFFFFED4, 32'd0,        8'h80, 1};
    vecs[3]  = '{16'd5,     5'd4,  2'b00, 8'd0,  32'd37,       32'hFFFFFFFE, 8'h0B, 0};
    vecs[4]  = '{16'd1,     5'd1,  2'b00, 8'd0,  32'hFFFFFFFD, 32'd0,        8'hFF, 0};
    vecs[5]  = '{16'd1,     5'd0,  2'b10, 8'd50, 32'd100,      32'd0,        8'h32, 0};
    vecs[6]  = '{16'd1,     5'd0,  2'b10, 8'd50, 32'd1000,     32'd0,        8'h32, 1};
    vecs[7]  = '{16'd2,     5'd0,  2'b11, 8'd0,  32'hFFFFFFFB, 32'd0,        8'hF6, 0};
    vecs[8]  = '{16'd1,     5'd31, 2'b00, 8'd0,  32'h7FFFFFFF, 32'd1,        8'h01, 0};
    vecs[9]  = '{16'd1,     5'd31, 2'b00, 8'd0,  32'h80000000, 32'hFFFFFFFF, 8'hFF, 0};
    vecs[10] = '{16'd65535, 5'd20, 2'b00, 8'd0,  32'd1000,     32'd0,        8'h3E, 0};
    vecs[11] = '{16'd1,     5'd0,  2'b00, 8'd0,  32'd127,      32'd0,        8'h7F, 0};
    vecs[12] = '{16'd1,     5'd0,  2'b00, 8'd0,  32'd128,      32'd0,        8'h7F, 1};
    vecs[13] = '{16'd1,     5'd0,  2'b00, 8'd0,  32'hFFFFFF80, 32'd0,        8'h80, 0};
    vecs[14] = '{16'd1,     5'd0,  2'b00, 8'd0,  32'hFFFFFF7F, 32'd0,        8'h80, 1};
    vecs[15] = '{16'd1,     5'd0,  2'b10, 8'd50, 32'hFFFFFFEC, 32'd0,        8'h00, 0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_acc = '0; in_bias = '0; cfg_base_addr = '0; cfg_scale = '0;
    cfg_shift = '0; cfg_act_mode = '0; cfg_clip_max = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_sat_count", sat_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vector(i, vecs[i]);

    run_count16("count16");

    // Twenty beats from the top address; a start pulse mid-job must be ignored.
    start_job(18'h3FFFF, 16'd1, 5'd0, 2'b00, 8'd0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        cfg_base_addr = 18'h00123;
        cfg_scale = 16'd7;
      end
      start = (i == 5);
      send_beat(32'd1, 32'd0, i == 19);
    end
    start = 1'b0;
    wait_idle("wrap20");
    check("wrap20_words", words.size(), 2);
    check_word("wrap20_w0", 0, 18'h3FFFF, {16{8'h01}}, 1'b0);
    check_word("wrap20_w1", 1, 18'h00000, 128'h01010101, 1'b1);

    // Hold the first word for ten cycles while later beats sit in the pipeline.
    out_ready = 1'b0;
    start_job(18'h00200, 16'd1, 5'd0, 2'b00, 8'd0);
    fork
      begin : stall_src
        for (int i = 0; i < 32; i++) send_beat(32'(i), 32'd0, i == 31);
      end
      begin : stall_sink
        int           t, bad;
        logic [127:0] d0;
        logic [17:0]  a0;
        t = 0;
        bad = 0;
        #1;
        while (!out_valid && t < 100) begin
          @(negedge clk);
          #1;
          t++;
        end
        check("stall_word_seen", out_valid, 1'b1);
        d0 = out_data;
        a0 = out_addr;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          #1;
          if (in_ready || !out_valid || out_data !== d0 || out_addr !== a0) bad++;
        end
        check("stall_hold", bad, 0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_idle("stall");
    for (int i = 0; i < 16; i++) begin
      exp0[i*8 +: 8] = 8'(i);
      exp1[i*8 +: 8] = 8'(i + 16);
    end
    check("stall_words", words.size(), 2);
    check_word("stall_w0", 0, 18'h00200, exp0, 1'b0);
    check_word("stall_w1", 1, 18'h00201, exp1, 1'b1);

    // Reset in the middle of a job, then the count16 job must repeat exactly.
    start_job(18'h00050, 16'd1, 5'd0, 2'b00, 8'd0);
    for (int i = 0; i < 5; i++) send_beat(32'd1000, 32'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sat_count", sat_count, 16'd0);
    @(negedge clk);
    run_count16("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
